// File: rtl/sb_dmem.sv
// ---------------------------------------------------------------------------
// sb_dmem : data-side system-bus responder for the CoNM core.
//
// Terminates the execute-stage load/store port and returns load data in the
// same cycle. Stores are posted through a one-entry write buffer that commits
// at the next rising edge. Loads that hit the buffered word see the buffered
// bytes. The block also keeps sticky error status and access counters.
//
// Request semantics: there is no ready/stall. A request is whatever
// mem_re_i / mem_we_i present in a cycle. It is classified in that same cycle
// and either accepted or rejected, and the decision is final.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   un_sign_i    1 = zero-extend the load, 0 = sign-extend
//   byte_mask_i  access size, unshifted (0001 byte, 0011 half, 1111 word)
//   mem_re_i     load request
//   mem_we_i     store request
//   addr_i       byte address
//   wdata_i      store data, right-aligned
//   rdata_o      load data, combinational, extended (0 when not loading)
//   err_o        sticky error flag
//   err_cause_o  first error cause: 1 misaligned, 2 out of range, 3 illegal
//   err_addr_o   address of the first error
//   ld_cnt_o     accepted loads, wrapping
//   st_cnt_o     accepted stores, wrapping
// ---------------------------------------------------------------------------
module sb_dmem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             un_sign_i,
    input  logic [3:0]       byte_mask_i,
    input  logic             mem_re_i,
    input  logic             mem_we_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             err_o,
    output logic [1:0]       err_cause_o,
    output logic [31:0]      err_addr_o,
    output logic [CNT_W-1:0] ld_cnt_o,
    output logic [CNT_W-1:0] st_cnt_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_RANGE    = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

    // ---------------------------------------------------------------
    // Request classification
    // ---------------------------------------------------------------
    logic          req;
    logic          is_byte, is_half, is_word;
    logic          illegal, misaligned, out_of_range;
    logic [1:0]    cause;
    logic          err_now;
    logic          ld_ok, st_ok;
    logic [AW-1:0] idx;
    logic [4:0]    lane_shift;

    assign req     = mem_re_i | mem_we_i;
    assign is_byte = (byte_mask_i == 4'b0001);
    assign is_half = (byte_mask_i == 4'b0011);
    assign is_word = (byte_mask_i == 4'b1111);

    assign illegal      = (mem_re_i & mem_we_i) | ~(is_byte | is_half | is_word);
    assign misaligned   = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));
    // In range means every address bit above the word index is zero.
    assign out_of_range = (addr_i[31:AW+2] != '0);

    always_comb begin
        cause = CAUSE_NONE;
        if (illegal)           cause = CAUSE_ILLEGAL;
        else if (misaligned)   cause = CAUSE_MISALIGN;
        else if (out_of_range) cause = CAUSE_RANGE;
    end

    assign err_now    = req & (cause != CAUSE_NONE);
    assign ld_ok      = mem_re_i & ~err_now;
    assign st_ok      = mem_we_i & ~err_now;
    assign idx        = addr_i[AW+1:2];
    assign lane_shift = {addr_i[1:0], 3'b000};

    // ---------------------------------------------------------------
    // One-entry write buffer
    // A valid entry always commits on the next edge, so a new store in
    // that same cycle can be captured on the edge that retires the old one.
    // ---------------------------------------------------------------
    logic          wb_valid;
    logic [AW-1:0] wb_idx;
    logic [3:0]    wb_be;
    logic [31:0]   wb_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid <= 1'b0;
            wb_idx   <= '0;
            wb_be    <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= st_ok;
            if (st_ok) begin
                wb_idx  <= idx;
                wb_be   <= byte_mask_i << addr_i[1:0];
                wb_data <= wdata_i << lane_shift;
            end
        end
    end

    // ---------------------------------------------------------------
    // Storage array (contents are not reset). Because wb_valid clears
    // asynchronously, an entry pending at reset is never written.
    // ---------------------------------------------------------------
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wb_valid) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_be[b]) mem[wb_idx][8*b +: 8] <= wb_data[8*b +: 8];
            end
        end
    end

    // ---------------------------------------------------------------
    // Combinational load path with forwarding from the write buffer
    // ---------------------------------------------------------------
    logic [31:0] arr_word;
    logic [31:0] merged;
    logic [31:0] shifted;
    logic        fwd_hit;

    assign arr_word = mem[idx];
    assign fwd_hit  = wb_valid & (wb_idx == idx);

    always_comb begin
        merged = arr_word;
        for (int b = 0; b < 4; b++) begin
            if (fwd_hit && wb_be[b]) merged[8*b +: 8] = wb_data[8*b +: 8];
        end
    end

    assign shifted = merged >> lane_shift;

    always_comb begin
        rdata_o = '0;
        if (ld_ok) begin
            if (is_byte)      rdata_o = {{24{~un_sign_i & shifted[7]}},  shifted[7:0]};
            else if (is_half) rdata_o = {{16{~un_sign_i & shifted[15]}}, shifted[15:0]};
            else              rdata_o = shifted;
        end
    end

    // ---------------------------------------------------------------
    // Sticky first-error capture and wrapping access counters
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_o       <= 1'b0;
            err_cause_o <= CAUSE_NONE;
            err_addr_o  <= '0;
        end else if (err_now && !err_o) begin
            err_o       <= 1'b1;
            err_cause_o <= cause;
            err_addr_o  <= addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_cnt_o <= '0;
            st_cnt_o <= '0;
        end else begin
            if (ld_ok) ld_cnt_o <= ld_cnt_o + CNT_W'(1);
            if (st_ok) st_cnt_o <= st_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sb_dmem.sv
// ---------------------------------------------------------------------------
// tb_sb_dmem : directed self-checking bench for sb_dmem.
// Instance uses DEPTH_WORDS=1024 and CNT_W=4 so counter wrap is reachable.
// Inputs change 1 ns after a rising edge. Combinational rdata is checked
// mid-cycle, and registered outputs are checked 1 ns after the edge.
// ---------------------------------------------------------------------------
module tb_sb_dmem;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        un_sign;
    logic [3:0]  byte_mask;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  err_cause;
    logic [31:0] err_addr;
    logic [3:0]  ld_cnt;
    logic [3:0]  st_cnt;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    sb_dmem #(.DEPTH_WORDS(1024), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .un_sign_i(un_sign), .byte_mask_i(byte_mask),
        .mem_re_i(mem_re), .mem_we_i(mem_we),
        .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata), .err_o(err), .err_cause_o(err_cause),
        .err_addr_o(err_addr), .ld_cnt_o(ld_cnt), .st_cnt_o(st_cnt)
    );

    // driver tasks
    task automatic set_req(input logic re, input logic we, input logic us,
                           input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
        mem_re = re; mem_we = we; un_sign = us; byte_mask = m; addr = a; wdata = d;
    endtask

    task automatic set_idle();
        set_req(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0;
        set_idle();
        tick();
        checks++;
        if ({err, err_cause, err_addr, ld_cnt, st_cnt} !== 43'h0) begin
            failures++;
            $display("FAIL reset_regs got err=%b cause=%0d addr=%h ld=%0d st=%0d exp all 0",
                     err, err_cause, err_addr, ld_cnt, st_cnt);
        end
        checks++;
        if (dut.wb_valid !== 1'b0) begin
            failures++; $display("FAIL reset_wb_valid got=%b exp=0", dut.wb_valid);
        end
        checks++;
        if (rdata !== 32'h0) begin
            failures++; $display("FAIL reset_rdata got=%h exp=0", rdata);
        end
        rst = 1'b1;
        tick();
    endtask

    // ---------------------------------------------------------------
    task automatic test_word_store_load();
        do_reset();
        set_req(1'b0, 1'b1, 1'b0, 4'b1111, 32'h10, 32'hDEADBEEF); tick();
        set_req(1'b1, 1'b0, 1'b0, 4'b1111, 32'h10, 32'h0); #1;
        checks++;
        if (rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL word_fwd got=%h exp=deadbeef", rdata);
        end
        tick();
        set_idle(); tick();
        set_req(1'b1, 1'b0, 1'b0, 4'b1111, 32'h10, 32'h0); #1;
        checks++;
        if (rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL word_array got=%h exp=deadbeef", rdata);
        end
        tick();
        set_idle();
        checks++;
        if (st_cnt !== 4'd1 || ld_cnt !== 4'd2) begin
            failures++; $display("FAIL word_counts got st=%0d ld=%0d exp st=1 ld=2", st_cnt, ld_cnt);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++; $display("FAIL word_no_err got=%b exp=0", err);
        end
    endtask

    // ---------------------------------------------------------------
    task automatic test_byte_half();
        do_reset();
        set_req(1'b0, 1'b1, 1'b0, 4'b1111, 32'h20, 32'h11223344); tick();
        set_idle(); tick();
        set_req(1'b0, 1'b1, 1'b0, 4'b0001, 32'h22, 32'h00000080); tick();
        set_req(1'b1, 1'b0, 1'b0, 4'b0001, 32'h22, 32'h0); #1;
        checks++;
        if (rdata !== 32'hFFFFFF80) begin
            failures++; $display("FAIL byte_signed got=%h exp=ffffff80", rdata);
        end
        un_sign = 1'b1; #1;
        checks++;
        if (rdata !== 32'h00000080) begin
            failures++; $display("FAIL byte_unsigned got=%h exp=00000080", rdata);
        end
        tick();
        set_req(1'b1, 1'b0, 1'b0, 4'b1111, 32'h20, 32'h0); #1;
        checks++;
        if (rdata !== 32'h11803344) begin
            failures++; $display("FAIL byte_merged_word got=%h exp=11803344", rdata);
        end
        tick();
        set_req(1'b1, 1'b0, 1'b1, 4'b0011, 32'h22, 32'h0); #1;
        checks++;
        if (rdata !== 32'h00001180) begin
            failures++; $display("FAIL half_upper_unsigned got=%h exp=00001180", rdata);
        end
        tick();
        // negative half in the upper lanes, forwarded then from array
        set_req(1'b0, 1'b1, 1'b0, 4'b0011, 32'h26, 32'h00009ABC); tick();
        set_req(1'b1, 1'b0, 1'b0, 4'b0011, 32'h26, 32'h0); #1;
        checks++;
        if (rdata !== 32'hFFFF9ABC) begin
            failures++; $display("FAIL half_signed_fwd got=%h exp=ffff9abc", rdata);
        end
        tick();
        set_req(1'b1, 1'b0, 1'b1, 4'b0011, 32'h26, 32'h0); #1;
        checks++;
        if (rdata !== 32'h00009ABC) begin
            failures++; $display("FAIL half_unsigned_array got=%h exp=00009abc", rdata);
        end
        tick();
        set_idle();
    endtask

    // ---------------------------------------------------------------
    task automatic test_misaligned();
        do_reset();
        set_req(1'b0, 1'b1, 1'b0, 4'b1111, 32'h10, 32'h12345678); tick();
        set_req(1'b0, 1'b1, 1'b0, 4'b0011, 32'h13, 32'h0000FFFF); tick();
        checks++;
        if (err !== 1'b1 || err_cause !== 2'd1 || err_addr !== 32'h13) begin
            failures++;
            $display("FAIL misalign_capture got err=%b cause=%0d addr=%h exp err=1 cause=1 addr=00000013",
                     err, err_cause, err_addr);
        end
        checks++;
        if (st_cnt !== 4'd1) begin
            failures++; $display("FAIL misalign_st_cnt got=%0d exp=1", st_cnt);
        end
        set_req(1'b1, 1'b0, 1'b0, 4'b1111, 32'h10, 32'h0); #1;
        checks++;
        if (rdata !== 32'h12345678) begin
            failures++; $display("FAIL misalign_no_write got=%h exp=12345678", rdata);
        end
        tick();
        set_idle();
        checks++;
        if (err !== 1'b1 || err_cause !== 2'd1 || err_addr !== 32'h13 || ld_cnt !== 4'd1) begin
            failures++;
            $display("FAIL misalign_sticky got err=%b cause=%0d addr=%h ld=%0d exp err=1 cause=1 addr=00000013 ld=1",
                     err, err_cause, err_addr, ld_cnt);
        end
    endtask

    // ---------------------------------------------------------------
    task automatic test_back_to_back();
        logic [31:0] exp;
        do_reset();
        set_req(1'b0, 1'b1, 1'b0, 4'b1111, 32'h0, 32'h0000000A); exp_q.push_back(32'hA); tick();
        set_req(1'b0, 1'b1, 1'b0, 4'b1111, 32'h4, 32'h0000000B); exp_q.push_back(32'hB); tick();
        for (int i = 0; i < 2; i++) begin
            set_req(1'b1, 1'b0, 1'b0, 4'b1111, 32'(4 * i), 32'h0); #1;
            exp = exp_q.pop_front();
            checks++;
            if (rdata !== exp) begin
                failures++; $display("FAIL b2b_load%0d got=%h exp=%h", i, rdata, exp);
            end
            tick();
        end
        set_idle();
        checks++;
        if (st_cnt !== 4'd2 || ld_cnt !== 4'd2) begin
            failures++; $display("FAIL b2b_counts got st=%0d ld=%0d exp st=2 ld=2", st_cnt, ld_cnt);
        end
        // 14 more stores: 16 in total wraps a 4-bit counter back to zero
        for (int i = 0; i < 14; i++) begin
            set_req(1'b0, 1'b1, 1'b0, 4'b1111, 32'h100 + 32'(4 * i), $urandom_range(1, 1000)); tick();
        end
        set_idle();
        checks++;
        if (st_cnt !== 4'd0 || ld_cnt !== 4'd2) begin
            failures++; $display("FAIL cnt_wrap got st=%0d ld=%0d exp st=0 ld=2", st_cnt, ld_cnt);
        end
    endtask

    // ---------------------------------------------------------------
    task automatic test_range_illegal();
        // 0x1000 aliases word 0 (holding 0xA) if the range check were missing
        do_reset();
        set_req(1'b1, 1'b0, 1'b0, 4'b1111, 32'h1000, 32'h0); #1;
        checks++;
        if (rdata !== 32'h0) begin
            failures++; $display("FAIL oor_rdata got=%h exp=0", rdata);
        end
        tick();
        set_idle();
        checks++;
        if (err !== 1'b1 || err_cause !== 2'd2 || err_addr !== 32'h1000 || ld_cnt !== 4'd0) begin
            failures++;
            $display("FAIL oor_capture got err=%b cause=%0d addr=%h ld=%0d exp err=1 cause=2 addr=00001000 ld=0",
                     err, err_cause, err_addr, ld_cnt);
        end
        // misaligned outranks out of range
        do_reset();
        set_req(1'b1, 1'b0, 1'b0, 4'b1111, 32'h1002, 32'h0); tick();
        set_idle();
        checks++;
        if (err_cause !== 2'd1 || err_addr !== 32'h1002) begin
            failures++; $display("FAIL prio_misalign_oor got cause=%0d addr=%h exp cause=1 addr=00001002",
                                 err_cause, err_addr);
        end
        // load+store together outranks misaligned; a later error does not overwrite
        do_reset();
        set_req(1'b1, 1'b1, 1'b0, 4'b0011, 32'h13, 32'h0); tick();
        set_req(1'b1, 1'b0, 1'b0, 4'b0111, 32'h44, 32'h0); tick();
        set_idle();
        checks++;
        if (err !== 1'b1 || err_cause !== 2'd3 || err_addr !== 32'h13 || st_cnt !== 4'd0 || ld_cnt !== 4'd0) begin
            failures++;
            $display("FAIL illegal_rw got err=%b cause=%0d addr=%h st=%0d ld=%0d exp err=1 cause=3 addr=00000013 st=0 ld=0",
                     err, err_cause, err_addr, st_cnt, ld_cnt);
        end
        // bad size mask alone
        do_reset();
        set_req(1'b1, 1'b0, 1'b0, 4'b0111, 32'h40, 32'h0); #1;
        checks++;
        if (rdata !== 32'h0) begin
            failures++; $display("FAIL illegal_mask_rdata got=%h exp=0", rdata);
        end
        tick();
        set_idle();
        checks++;
        if (err_cause !== 2'd3 || err_addr !== 32'h40) begin
            failures++; $display("FAIL illegal_mask got cause=%0d addr=%h exp cause=3 addr=00000040",
                                 err_cause, err_addr);
        end
    endtask

    // ---------------------------------------------------------------
    task automatic test_reset_mid_op();
        do_reset();
        set_req(1'b0, 1'b1, 1'b0, 4'b1111, 32'h30, 32'h0); tick();
        set_idle(); tick();
        // store presented, reset asserted before its capture edge
        set_req(1'b0, 1'b1, 1'b0, 4'b1111, 32'h30, 32'h5555AAAA); #2;
        rst = 1'b0; #1;
        checks++;
        if (st_cnt !== 4'd0) begin
            failures++; $display("FAIL midrst_async_cnt got=%0d exp=0", st_cnt);
        end
        @(posedge clk); #1;
        set_idle();
        rst = 1'b1;
        tick();
        set_req(1'b1, 1'b0, 1'b0, 4'b1111, 32'h30, 32'h0); #1;
        checks++;
        if (rdata !== 32'h0) begin
            failures++; $display("FAIL midrst_precapture got=%h exp=0", rdata);
        end
        tick();
        // store captured, reset asserted before its commit edge
        set_req(1'b1, 1'b1, 1'b0, 4'b1111, 32'h50, 32'h0); tick();
        set_req(1'b0, 1'b1, 1'b0, 4'b1111, 32'h30, 32'h5555AAAA); tick();
        checks++;
        if (dut.wb_valid !== 1'b1 || err !== 1'b1 || st_cnt !== 4'd1) begin
            failures++; $display("FAIL midrst_setup got wb=%b err=%b st=%0d exp wb=1 err=1 st=1",
                                 dut.wb_valid, err, st_cnt);
        end
        #1 rst = 1'b0; #1;
        checks++;
        if (dut.wb_valid !== 1'b0 || {err, err_cause, err_addr, ld_cnt, st_cnt} !== 43'h0) begin
            failures++;
            $display("FAIL midrst_clear got wb=%b err=%b cause=%0d addr=%h ld=%0d st=%0d exp all 0",
                     dut.wb_valid, err, err_cause, err_addr, ld_cnt, st_cnt);
        end
        set_idle();
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        set_req(1'b1, 1'b0, 1'b0, 4'b1111, 32'h30, 32'h0); #1;
        checks++;
        if (rdata !== 32'h0) begin
            failures++; $display("FAIL midrst_dropped got=%h exp=0", rdata);
        end
        tick();
        set_idle();
    endtask

    // ---------------------------------------------------------------
    initial begin
        set_idle();
        test_reset();
        test_word_store_load();
        test_byte_half();
        test_misaligned();
        test_back_to_back();
        test_range_illegal();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // overall time bound
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sb_dmem.md
# sb_dmem

Data-side system-bus responder for the CoNM core. Terminates the core's execute-stage load/store port (`un_sign`, `byte_mask`, `mem_re`, `mem_we`, `addr`, `wdata`) and returns same-cycle load data to the register file write-back path. Stores are posted through a one-entry write buffer with load forwarding. The block also keeps sticky error status and access counters.

## Interface

Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words in the array (4 KiB). Must be a power of two.
- `CNT_W`, default 16: width of each access counter.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `un_sign_i`  in  1  1 = zero-extend the load, 0 = sign-extend.
- `byte_mask_i`  in  4  access size, unshifted: 4'b0001 byte, 4'b0011 half, 4'b1111 word.
- `mem_re_i`  in  1  load request, this cycle.
- `mem_we_i`  in  1  store request, this cycle.
- `addr_i`  in  32  byte address.
- `wdata_i`  in  32  store data, right-aligned.
- `rdata_o`  out  32  load data, combinational, extended.
- `err_o`  out  1  sticky error flag.
- `err_cause_o`  out  2  cause of the first error: 1 misaligned, 2 out of range, 3 illegal request.
- `err_addr_o`  out  32  `addr_i` of the first error.
- `ld_cnt_o`  out  CNT_W  count of accepted loads.
- `st_cnt_o`  out  CNT_W  count of accepted stores.

## Operation

Request classification is evaluated every cycle in which `mem_re_i | mem_we_i` is high:
- **Illegal request:** `mem_re_i & mem_we_i`, or `byte_mask_i` not in {0001, 0011, 1111}.
- **Misaligned:** half with `addr_i[0]`=1, or word with `addr_i[1:0]`≠0.
- **Out of range:** `addr_i >= DEPTH_WORDS*4`.
- **Priority:** illegal > misaligned > out of range.
- A request with any error is rejected. A rejected store has no effect on the array or buffer. A rejected load returns `rdata_o`=0.

Stores:
- An accepted store captures {word index `addr_i[..:2]`, `byte_mask_i << addr_i[1:0]`, `wdata_i << 8*addr_i[1:0]`} into the write buffer and sets `wb_valid`.
- A valid buffer commits its enabled bytes to the array at the next rising edge, unconditionally.
- A new store in the same cycle as a commit: the old entry is committed and the new one captured on the same edge. No stall is ever needed.

Loads (combinational):
- Read the array word at `addr_i[..:2]`.
- If `wb_valid` and the buffer index matches, substitute the buffered bytes in the enabled lanes (forwarding).
- Shift right by `8*addr_i[1:0]`, mask to the access size, then extend per `un_sign_i`.
- `rdata_o`=0 whenever `mem_re_i`=0.

Error capture:
- On the first rejected request, set `err_o` and latch `err_cause_o`/`err_addr_o`.
- Later errors do not overwrite the latched values. Only reset clears them.

Counters:
- `ld_cnt_o`/`st_cnt_o` increment on each accepted load/store.
- They wrap modulo 2^CNT_W and are not saturating.

## Timing

- **Load latency:** 0 cycles. `rdata_o` is valid in the same cycle as `mem_re_i`, before the clock edge at which the core writes rd.
- **Store visibility:**
  - A load in cycle N+1 after a store in cycle N sees the new data via forwarding.
  - From cycle N+2 the data is visible from the array.
- **Error and counter outputs:** registered. They update on the edge that ends the request cycle.
- **Reset (`rst`=0, asynchronous):**
  - `wb_valid`=0, `err_o`=0, `err_cause_o`=0, `err_addr_o`=0, `ld_cnt_o`=0, `st_cnt_o`=0.
  - `rdata_o` follows its combinational rule (0 when idle).
  - Array contents are not reset.
- **Reset mid-operation:** a store pending in the buffer when `rst` asserts is dropped and never committed.
- **Idle cycles** (`mem_re_i`=`mem_we_i`=0): no state change except a pending commit.

## Test plan

- **Word store, then load, then load again:** store word 0xDEADBEEF @0x10 in cycle N, load word @0x10 in N+1 -> `rdata_o`=0xDEADBEEF via forwarding. Load again in N+3 -> same value from the array. `st_cnt_o`=1, `ld_cnt_o`=2.
- **Byte store, then signed and unsigned byte loads:** prior word @0x20 = 0x11223344. Store byte 0x80 @0x22. Signed byte load @0x22 -> 0xFFFFFF80. Unsigned -> 0x00000080. Word load @0x20 -> 0x11803344.
- **Misaligned half store:** half store @0x13 -> `err_o`=1, `err_cause_o`=1, `err_addr_o`=0x13, no write. A following accepted error-free access leaves cause/addr unchanged.
- **Out-of-range and illegal requests:** out-of-range word load @0x1000 with DEPTH_WORDS=1024 -> `rdata_o`=0, `err_cause_o`=2. Separately after reset: `mem_re_i`=`mem_we_i`=1 -> `err_cause_o`=3.
- **Back-to-back stores with counter wrap:** stores to @0x0 (0xA) and @0x4 (0xB) in consecutive cycles -> both readable afterwards. With CNT_W=4, 16 accepted stores -> `st_cnt_o` wraps to 0.
- **Reset mid-operation:** store 0x5555AAAA @0x30 with `rst` asserted before the next edge -> after reset, `wb_valid`=0, all outputs reset, and a word load @0x30 does not return 0x5555AAAA (array pre-loaded with 0 by the bench reads 0).
